// File: rtl/ibex_register_file_wipe_ctrl.sv
// Register file write-port sequencer: passes core writebacks through, and on request
// takes over the port to overwrite x1..xN-1 with an optional LFSR pass, then a zero pass.
module ibex_register_file_wipe_ctrl #(
  parameter bit                   RV32E       = 1'b0,
  parameter int unsigned          DataWidth   = 32,
  parameter logic [DataWidth-1:0] WordZeroVal = '0,
  parameter bit                   RandomPass  = 1'b1,
  parameter logic [31:0]          LfsrSeed    = 32'hACE1_2468
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 wipe_req_i,
  output logic                 wipe_busy_o,
  output logic                 wipe_done_o,
  input  logic                 core_we_i,
  input  logic [4:0]           core_waddr_i,
  input  logic [DataWidth-1:0] core_wdata_i,
  output logic                 core_wready_o,
  output logic                 rf_we_o,
  output logic [4:0]           rf_waddr_o,
  output logic [DataWidth-1:0] rf_wdata_o,
  output logic                 err_o
);

  localparam logic [4:0]  LastAddr = RV32E ? 5'd15 : 5'd31;
  localparam logic [31:0] LfsrPoly = 32'h8020_0003;

  typedef enum logic [1:0] {
    IDLE,
    WIPE_RAND,
    WIPE_ZERO,
    DONE
  } state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] lfsr_q, lfsr_d;

  // Right-shifting Galois step; a non-zero state can never map to zero.
  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? LfsrPoly : 32'h0);
  endfunction

  function automatic logic [DataWidth-1:0] fit_word(input logic [31:0] s);
    return DataWidth'(s);
  endfunction

  assign err_o = RV32E && core_we_i && core_waddr_i[4];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lfsr_d  = lfsr_q;
    case (state_q)
      IDLE: begin
        if (wipe_req_i) begin
          if (RandomPass) state_d = WIPE_RAND;
          else            state_d = WIPE_ZERO;
        end
      end
      WIPE_RAND, WIPE_ZERO: begin
        if (state_q == WIPE_RAND) lfsr_d = lfsr_step(lfsr_q);
        if (cnt_q == LastAddr) begin
          cnt_d = 5'd1;
          if (state_q == WIPE_RAND) state_d = WIPE_ZERO;
          else                      state_d = DONE;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      DONE: state_d = IDLE;
    endcase
  end

  always_comb begin
    wipe_busy_o   = 1'b0;
    wipe_done_o   = 1'b0;
    core_wready_o = 1'b0;
    rf_we_o       = 1'b0;
    rf_waddr_o    = core_waddr_i;
    rf_wdata_o    = core_wdata_i;
    case (state_q)
      IDLE: begin
        core_wready_o = 1'b1;
        rf_we_o       = core_we_i & ~err_o;
      end
      WIPE_RAND: begin
        wipe_busy_o = 1'b1;
        rf_we_o     = 1'b1;
        rf_waddr_o  = cnt_q;
        rf_wdata_o  = fit_word(lfsr_q);
      end
      WIPE_ZERO: begin
        wipe_busy_o = 1'b1;
        rf_we_o     = 1'b1;
        rf_waddr_o  = cnt_q;
        rf_wdata_o  = WordZeroVal;
      end
      DONE: wipe_done_o = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= 5'd1;
      lfsr_q  <= LfsrSeed;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lfsr_q  <= lfsr_d;
    end
  end

endmodule

// File: tb/tb_ibex_register_file_wipe_ctrl.sv
// Bench for the register file wipe controller: an RV32I/RandomPass instance and an
// RV32E/zero-only instance, checked against a queue-based write-sequence model.
module tb_ibex_register_file_wipe_ctrl;

  localparam logic [31:0] SEED = 32'hACE1_2468;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        wreq_i = 0, we_i = 0;
  logic [4:0]  waddr_i = 0;
  logic [31:0] wdata_i = 0;
  logic        busy_i, done_i, wready_i, rf_we_i, err_i;
  logic [4:0]  rf_waddr_i;
  logic [31:0] rf_wdata_i;

  logic        wreq_e = 0, we_e = 0;
  logic [4:0]  waddr_e = 0;
  logic [31:0] wdata_e = 0;
  logic        busy_e, done_e, wready_e, rf_we_e, err_e;
  logic [4:0]  rf_waddr_e;
  logic [31:0] rf_wdata_e;

  ibex_register_file_wipe_ctrl dut_i (
    .clk_i(clk), .rst_ni(rst_n), .wipe_req_i(wreq_i), .wipe_busy_o(busy_i),
    .wipe_done_o(done_i), .core_we_i(we_i), .core_waddr_i(waddr_i), .core_wdata_i(wdata_i),
    .core_wready_o(wready_i), .rf_we_o(rf_we_i), .rf_waddr_o(rf_waddr_i),
    .rf_wdata_o(rf_wdata_i), .err_o(err_i)
  );

  ibex_register_file_wipe_ctrl #(.RV32E(1'b1), .RandomPass(1'b0)) dut_e (
    .clk_i(clk), .rst_ni(rst_n), .wipe_req_i(wreq_e), .wipe_busy_o(busy_e),
    .wipe_done_o(done_e), .core_we_i(we_e), .core_waddr_i(waddr_e), .core_wdata_i(wdata_e),
    .core_wready_o(wready_e), .rf_we_o(rf_we_e), .rf_waddr_o(rf_waddr_e),
    .rf_wdata_o(rf_wdata_e), .err_o(err_e)
  );

  int n_vec = 0, n_err = 0;
  int n_done = 0, n_done_e = 0, n9 = 0;
  logic [31:0] rf_model [32];
  logic [31:0] m_lfsr = SEED;

  // Register file fed by the RV32I instance's write port.
  always @(posedge clk) begin
    if (rf_we_i && rf_waddr_i != 5'd0) rf_model[rf_waddr_i] <= rf_wdata_i;
    if (done_i) n_done <= n_done + 1;
    if (done_e) n_done_e <= n_done_e + 1;
    if (rf_we_i && wready_i && rf_waddr_i == 5'd9) n9 <= n9 + 1;
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    logic [31:0] poly;
    poly = 32'h8020_0003;
    return s[0] ? ((s >> 1) ^ poly) : (s >> 1);
  endfunction

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_busy"}, busy_i, 1'b0);
    check_eq({tag, "_done"}, done_i, 1'b0);
    check_eq({tag, "_rdy"}, wready_i, 1'b1);
    check_eq({tag, "_we"}, rf_we_i, 1'b0);
    check_eq({tag, "_err"}, err_i, 1'b0);
  endtask

  task automatic wipe_i(input bit collide, input bit hold_wr, input int abort_at, input bit fresh);
    logic [36:0] exp_q[$];
    logic [36:0] e;
    logic [31:0] hold_d;
    int          done0, n90;
    for (int p = 0; p < 2; p++) begin
      for (int a = 1; a < 32; a++) begin
        exp_q.push_back({5'(a), (p == 0) ? m_lfsr : 32'h0});
        if (p == 0) m_lfsr = lfsr_next(m_lfsr);
      end
    end
    done0  = n_done;
    n90    = n9;
    hold_d = $urandom;
    wreq_i = 1'b1;
    if (collide) begin
      we_i = 1'b1; waddr_i = 5'd7; wdata_i = 32'h1234;
    end
    #1;
    if (collide) begin
      check_eq("coll_we", rf_we_i, 1'b1);
      check_eq("coll_addr", rf_waddr_i, 5'd7);
      check_eq("coll_data", rf_wdata_i, 32'h1234);
      check_eq("coll_rdy", wready_i, 1'b1);
    end
    tick();
    wreq_i = 1'b0;
    we_i   = 1'b0;
    for (int k = 1; k <= 62; k++) begin
      if (hold_wr && k == 5) begin
        we_i = 1'b1; waddr_i = 5'd9; wdata_i = hold_d;
      end
      if (k == 20) wreq_i = 1'b1;
      if (k == 21) wreq_i = 1'b0;
      #1;
      e = exp_q.pop_front();
      check_eq("w_busy", busy_i, 1'b1);
      check_eq("w_rdy", wready_i, 1'b0);
      check_eq("w_done", done_i, 1'b0);
      check_eq("w_we", rf_we_i, 1'b1);
      check_eq("w_addr", rf_waddr_i, e[36:32]);
      check_eq("w_data", rf_wdata_i, e[31:0]);
      if (fresh && k == 1) check_eq("first_word", rf_wdata_i, SEED);
      if (k == abort_at) begin
        rst_n = 1'b0;
        #1;
        check_reset_outputs("abort");
        m_lfsr = SEED;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        return;
      end
      tick();
    end
    check_eq("done_pulse", done_i, 1'b1);
    check_eq("done_busy", busy_i, 1'b0);
    check_eq("done_we", rf_we_i, 1'b0);
    check_eq("done_rdy", wready_i, 1'b0);
    tick();
    check_eq("idle_done", done_i, 1'b0);
    check_eq("idle_rdy", wready_i, 1'b1);
    if (hold_wr) begin
      check_eq("held_we", rf_we_i, 1'b1);
      check_eq("held_addr", rf_waddr_i, 5'd9);
      check_eq("held_data", rf_wdata_i, hold_d);
      tick();
      we_i = 1'b0;
    end
    for (int j = 0; j < 3; j++) begin
      #1;
      check_eq("post_busy", busy_i, 1'b0);
      tick();
    end
    check_eq("done_count", 32'(n_done - done0), 32'd1);
    if (hold_wr) check_eq("held_once", 32'(n9 - n90), 32'd1);
    for (int r = 1; r < 32; r++)
      check_eq($sformatf("readback_x%0d", r), rf_model[r],
               (hold_wr && r == 9) ? hold_d : 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    #1;
    check_reset_outputs("rst");
    check_eq("rst_err_e", err_e, 1'b0);
    check_eq("rst_rdy_e", wready_e, 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Pass-through, first vector fixed, remainder random (includes addr >= 16 on RV32I).
    for (int i = 0; i < 13; i++) begin
      we_i    = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      waddr_i = (i == 0) ? 5'd5 : 5'($urandom);
      wdata_i = (i == 0) ? 32'hDEAD_BEEF : $urandom;
      #1;
      check_eq("pt_we", rf_we_i, we_i);
      check_eq("pt_addr", rf_waddr_i, waddr_i);
      check_eq("pt_data", rf_wdata_i, wdata_i);
      check_eq("pt_rdy", wready_i, 1'b1);
      check_eq("pt_err", err_i, 1'b0);
      tick();
    end
    we_i = 1'b0;

    wipe_i(1'b1, 1'b1, 0, 1'b1);
    wipe_i(1'b0, 1'b0, 41, 1'b0);
    #1;
    check_reset_outputs("post_rst");
    wipe_i(1'b0, 1'b0, 0, 1'b1);

    // RV32E: illegal-address detection on random core writes.
    for (int i = 0; i < 16; i++) begin
      we_e    = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      waddr_e = (i == 0) ? 5'd20 : 5'($urandom);
      wdata_e = $urandom;
      #1;
      check_eq("e_err", err_e, we_e & waddr_e[4]);
      check_eq("e_we", rf_we_e, we_e & ~waddr_e[4]);
      check_eq("e_rdy", wready_e, 1'b1);
      check_eq("e_addr", rf_waddr_e, waddr_e);
      tick();
    end
    we_e = 1'b0;

    wreq_e = 1'b1;
    tick();
    wreq_e = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      check_eq("e_w_busy", busy_e, 1'b1);
      check_eq("e_w_rdy", wready_e, 1'b0);
      check_eq("e_w_we", rf_we_e, 1'b1);
      check_eq("e_w_addr", rf_waddr_e, 5'(k));
      check_eq("e_w_data", rf_wdata_e, 32'h0);
      tick();
    end
    check_eq("e_done", done_e, 1'b1);
    check_eq("e_done_busy", busy_e, 1'b0);
    check_eq("e_done_we", rf_we_e, 1'b0);
    tick();
    check_eq("e_idle_rdy", wready_e, 1'b1);
    check_eq("e_idle_done", done_e, 1'b0);
    tick();
    check_eq("e_done_count", 32'(n_done_e), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
